// File: rtl/anb_wr_burst_splitter_m.sv
// ANB write burst splitter: re-issues master write bursts as bounded sub-bursts and regenerates last.
// Optional ANB_WR_SPLIT_OUT_REG_EN adds 2-entry register slices on the s_a and s_d channels.
module anb_wr_burst_splitter_m #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned MAX_BEATS   = 16,
    parameter int unsigned BOUND_BYTES = 4096,
    parameter int unsigned LFIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_avalid,
    output logic              m_aready,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [LEN_W-1:0]  m_len,
    output logic              s_avalid,
    input  logic              s_aready,
    output logic [ADDR_W-1:0] s_addr,
    output logic [LEN_W-1:0]  s_len,
    input  logic              m_dvalid,
    output logic              m_dready,
    input  logic [DATA_W-1:0] m_data,
    input  logic              m_last,
    output logic              s_dvalid,
    input  logic              s_dready,
    output logic [DATA_W-1:0] s_data,
    output logic              s_last,
    output logic              last_err
);
    localparam int unsigned BEAT_B      = DATA_W / 8;
    localparam int unsigned BEAT_SH     = $clog2(BEAT_B);
    localparam int unsigned BOUND_SH    = $clog2(BOUND_BYTES);
    localparam int unsigned BOUND_BEATS = BOUND_BYTES / BEAT_B;
    localparam int unsigned PTR_W       = (LFIFO_DEPTH > 1) ? $clog2(LFIFO_DEPTH) : 1;
    localparam int unsigned CNT_W       = $clog2(LFIFO_DEPTH + 1);
    localparam int unsigned RW          = LEN_W + 1;

    typedef enum logic [0:0] {StIdle, StSplit} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [RW-1:0]     rem_q;
    logic              av_q;
    logic [ADDR_W-1:0] aaddr_q;
    logic [LEN_W-1:0]  alen_q;
    logic              m_aready_q;
    logic              last_err_q;

    logic              a_rdy, d_rdy, d_valid, d_last, d_hs;
    logic              m_hs, a_hs, issue;
    logic [ADDR_W-1:0] src_addr;
    logic [RW-1:0]     src_rem, n, rem_after;
    logic [31:0]       room, n32;

    // Length FIFO: {final sub-burst of master burst, beat count}
    logic [RW:0]       lmem [LFIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]     bcnt_q;
    logic              lfifo_full, lfifo_nempty, pop;
    logic [RW:0]       head;

    assign lfifo_full   = (cnt_q == CNT_W'(LFIFO_DEPTH));
    assign lfifo_nempty = (cnt_q != '0);
    assign head         = lmem[rptr_q];

    always_comb begin
        m_hs = m_avalid & m_aready_q;
        a_hs = av_q & a_rdy;
        if (state_q == StIdle) begin
            src_addr = m_addr & ~ADDR_W'(BEAT_B - 1);
            src_rem  = RW'(m_len) + RW'(1);
        end else begin
            src_addr = addr_q;
            src_rem  = rem_q;
        end
        room = BOUND_BEATS - 32'(src_addr[BOUND_SH-1:BEAT_SH]);
        n32  = 32'(src_rem);
        if (n32 > MAX_BEATS) n32 = MAX_BEATS;
        if (n32 > room)      n32 = room;
        n         = RW'(n32);
        rem_after = src_rem - n;
        if (state_q == StIdle) issue = m_hs;
        else issue = (!av_q || a_hs) && (rem_q != '0) && !lfifo_full;
    end

    assign pop   = d_hs & d_last;
    assign cnt_d = cnt_q + CNT_W'(issue) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rem_q      <= '0;
            av_q       <= 1'b0;
            aaddr_q    <= '0;
            alen_q     <= '0;
            m_aready_q <= 1'b0;
        end else begin
            if (issue) begin
                av_q    <= 1'b1;
                aaddr_q <= src_addr;
                alen_q  <= LEN_W'(n - RW'(1));
                addr_q  <= src_addr + (ADDR_W'(n) << BEAT_SH);
                rem_q   <= rem_after;
            end else if (a_hs) begin
                av_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (m_hs) state_q <= StSplit;
                    m_aready_q <= !m_hs && (cnt_d < CNT_W'(LFIFO_DEPTH));
                end
                StSplit: begin
                    if (a_hs && rem_q == '0) begin
                        state_q    <= StIdle;
                        m_aready_q <= (cnt_d < CNT_W'(LFIFO_DEPTH));
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue) lmem[wptr_q] <= {rem_after == '0, n};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            last_err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (issue) wptr_q <= (wptr_q == PTR_W'(LFIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
            if (pop)   rptr_q <= (rptr_q == PTR_W'(LFIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
            if (d_hs) begin
                bcnt_q <= d_last ? '0 : bcnt_q + RW'(1);
                // Master burst ends on the last beat of its final sub-burst
                if (m_last != (d_last && head[RW])) last_err_q <= 1'b1;
            end
        end
    end

    assign d_valid  = m_dvalid & lfifo_nempty;
    assign d_last   = lfifo_nempty && (bcnt_q == head[RW-1:0] - RW'(1));
    assign d_hs     = d_valid & d_rdy;
    assign m_dready = d_rdy & lfifo_nempty;
    assign m_aready = m_aready_q;
    assign last_err = last_err_q;

`ifdef ANB_WR_SPLIT_OUT_REG_EN
    logic [ADDR_W+LEN_W-1:0] a_out;
    logic [DATA_W:0]         d_out;

    reg_stage_m #(.W(ADDR_W + LEN_W)) u_a_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (av_q),
        .in_ready  (a_rdy),
        .in_data   ({aaddr_q, alen_q}),
        .out_valid (s_avalid),
        .out_ready (s_aready),
        .out_data  (a_out)
    );

    reg_stage_m #(.W(DATA_W + 1)) u_d_slice (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d_valid),
        .in_ready  (d_rdy),
        .in_data   ({d_last, m_data}),
        .out_valid (s_dvalid),
        .out_ready (s_dready),
        .out_data  (d_out)
    );

    assign s_addr = a_out[ADDR_W+LEN_W-1:LEN_W];
    assign s_len  = a_out[LEN_W-1:0];
    assign s_last = d_out[DATA_W];
    assign s_data = d_out[DATA_W-1:0];
`else
    assign s_avalid = av_q;
    assign s_addr   = aaddr_q;
    assign s_len    = alen_q;
    assign a_rdy    = s_aready;
    assign s_dvalid = d_valid;
    assign s_data   = m_data;
    assign s_last   = d_last;
    assign d_rdy    = s_dready;
`endif

endmodule

`ifdef ANB_WR_SPLIT_OUT_REG_EN
// Two-entry full-throughput register slice; in_ready depends only on local state.
module reg_stage_m #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] buf_q [2];
    logic         wr_q, rd_q, push, pop;
    logic [1:0]   cnt_q;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = buf_q[rd_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop) rd_q <= ~rd_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end
endmodule
`endif

// File: tb/tb_anb_wr_burst_splitter_m.sv
// Scoreboard bench for anb_wr_burst_splitter_m: directed bursts, queued expectations, negedge monitors.
module tb_anb_wr_burst_splitter_m;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_avalid, m_aready, s_avalid, s_aready;
    logic [31:0] m_addr, s_addr;
    logic [7:0]  m_len, s_len;
    logic        m_dvalid, m_dready, m_last, s_dvalid, s_dready, s_last, last_err;
    logic [63:0] m_data, s_data;

    always #5 clk = ~clk;

    anb_wr_burst_splitter_m #(
        .ADDR_W(32), .LEN_W(8), .DATA_W(64), .MAX_BEATS(16), .BOUND_BYTES(4096), .LFIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m_avalid(m_avalid), .m_aready(m_aready), .m_addr(m_addr), .m_len(m_len),
        .s_avalid(s_avalid), .s_aready(s_aready), .s_addr(s_addr), .s_len(s_len),
        .m_dvalid(m_dvalid), .m_dready(m_dready), .m_data(m_data), .m_last(m_last),
        .s_dvalid(s_dvalid), .s_dready(s_dready), .s_data(s_data), .s_last(s_last),
        .last_err(last_err)
    );

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } a_t;
    typedef struct packed { logic [63:0] data; logic last; } d_t;

    a_t exp_a[$];
    d_t exp_d[$];
    int lastq[$];
    int n_checks = 0;
    int n_fail   = 0;
    int na_seen  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic push_a(input logic [31:0] a, input logic [7:0] l);
        a_t e;
        e.addr = a;
        e.len  = l;
        exp_a.push_back(e);
    endtask

    // Expected beats; lastq holds hand-computed 1-based beat numbers carrying s_last
    task automatic push_data(input logic [7:0] tag, input int n);
        d_t e;
        for (int i = 0; i < n; i++) begin
            e.data = {tag, 56'(i)};
            e.last = 1'b0;
            foreach (lastq[k]) if (lastq[k] == i + 1) e.last = 1'b1;
            exp_d.push_back(e);
        end
    endtask

    task automatic send_addr(input logic [31:0] a, input logic [7:0] l);
        int t = 0;
        m_avalid = 1'b1;
        m_addr   = a;
        m_len    = l;
        do begin @(negedge clk); t++; end while (!m_aready && t < 500);
        if (!m_aready) timeout("m_aready");
        @(posedge clk); #1;
        m_avalid = 1'b0;
    endtask

    task automatic send_data(input int n, input int errbeat, input logic [7:0] tag);
        int t;
        for (int i = 0; i < n; i++) begin
            m_dvalid = 1'b1;
            m_data   = {tag, 56'(i)};
            m_last   = (errbeat != 0) ? (i + 1 == errbeat) : (i == n - 1);
            t = 0;
            do begin @(negedge clk); t++; end while (!m_dready && t < 2000);
            if (!m_dready) begin
                timeout("m_dready");
                break;
            end
            @(posedge clk); #1;
        end
        m_dvalid = 1'b0;
        m_last   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_a.size() != 0 || exp_d.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(name, 64'(exp_a.size() + exp_d.size()), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_m_aready"}, 64'(m_aready), 64'd0);
        check({tag, "_s_avalid"}, 64'(s_avalid), 64'd0);
        check({tag, "_s_addr"},   64'(s_addr),   64'd0);
        check({tag, "_s_len"},    64'(s_len),    64'd0);
        check({tag, "_s_dvalid"}, 64'(s_dvalid), 64'd0);
        check({tag, "_s_last"},   64'(s_last),   64'd0);
        check({tag, "_last_err"}, 64'(last_err), 64'd0);
    endtask

    always @(negedge clk) begin : mon_a
        a_t e;
        if (rst && s_avalid && s_aready) begin
            na_seen++;
            if (exp_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_a_unexpected: got addr 0x%0h len %0d, none expected", s_addr, s_len);
            end else begin
                e = exp_a.pop_front();
                check("s_addr", 64'(s_addr), 64'(e.addr));
                check("s_len", 64'(s_len), 64'(e.len));
            end
        end
    end

    always @(negedge clk) begin : mon_d
        d_t e;
        if (rst && s_dvalid && s_dready) begin
            if (exp_d.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_d_unexpected: got data 0x%0h, none expected", s_data);
            end else begin
                e = exp_d.pop_front();
                check("s_data", s_data, e.data);
                check("s_last", 64'(s_last), 64'(e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        m_avalid = 1'b0; m_addr = '0; m_len = '0;
        m_dvalid = 1'b0; m_data = '0; m_last = 1'b0;
        s_aready = 1'b1; s_dready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b1;

        // 40 beats from 0: three sub-bursts limited by MAX_BEATS
        push_a(32'h000, 8'd15); push_a(32'h080, 8'd15); push_a(32'h100, 8'd7);
        lastq = '{16, 32, 40};
        push_data(8'd1, 40);
        fork
            send_addr(32'h0, 8'd39);
            send_data(40, 0, 8'd1);
        join
        wait_drain("t1_drain");

        // 4 KiB boundary split
        push_a(32'h0FC0, 8'd7); push_a(32'h1000, 8'd7);
        lastq = '{8, 16};
        push_data(8'd2, 16);
        fork
            send_addr(32'h0FC0, 8'd15);
            send_data(16, 0, 8'd2);
        join
        wait_drain("t2_drain");

        // Single beat
        push_a(32'h0010, 8'd0);
        lastq = '{1};
        push_data(8'd3, 1);
        fork
            send_addr(32'h0010, 8'd0);
            send_data(1, 0, 8'd3);
        join
        wait_drain("t3_drain");
        check("t3_last_err", 64'(last_err), 64'd0);

        // s_aready held low: sub-burst must stay stable
        s_aready = 1'b0;
        push_a(32'h2000, 8'd15);
        lastq = '{16};
        push_data(8'd4, 16);
        fork
            send_addr(32'h2000, 8'd15);
            send_data(16, 0, 8'd4);
            begin
                t = 0;
                do begin @(posedge clk); #1; t++; end while (!s_avalid && t < 50);
                check("stall_seen", 64'(s_avalid), 64'd1);
                repeat (5) begin
                    check("stall_avalid", 64'(s_avalid), 64'd1);
                    check("stall_addr", 64'(s_addr), 64'h2000);
                    check("stall_len", 64'(s_len), 64'd15);
                    @(posedge clk); #1;
                end
                s_aready = 1'b1;
            end
        join
        wait_drain("t4_drain");

        // s_dready low: address side runs ahead by exactly LFIFO_DEPTH sub-bursts
        s_dready = 1'b0;
        base = na_seen;
        push_a(32'h3000, 8'd15); push_a(32'h3080, 8'd15); push_a(32'h3100, 8'd15);
        push_a(32'h3180, 8'd15); push_a(32'h3200, 8'd15);
        lastq = '{16, 32, 48, 64, 80};
        push_data(8'd5, 80);
        fork
            send_addr(32'h3000, 8'd79);
            send_data(80, 0, 8'd5);
            begin
                repeat (20) @(posedge clk);
                #1;
                check("full_s_avalid", 64'(s_avalid), 64'd0);
                check("full_m_aready", 64'(m_aready), 64'd0);
                check("full_issued", 64'(na_seen - base), 64'd4);
                s_dready = 1'b1;
            end
        join
        wait_drain("t5_drain");

        // Early m_last on beat 10: error flag, beats still forwarded
        push_a(32'h0400, 8'd15);
        lastq = '{16};
        push_data(8'd6, 16);
        fork
            send_addr(32'h0400, 8'd15);
            send_data(16, 10, 8'd6);
        join
        wait_drain("t6_drain");
        check("t6_last_err", 64'(last_err), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_last_err_sticky", 64'(last_err), 64'd1);

        // Reset during second of three sub-bursts
        s_dready = 1'b0;
        push_a(32'h5000, 8'd15); push_a(32'h5080, 8'd15); push_a(32'h5100, 8'd15);
        send_addr(32'h5000, 8'd47);
        t = 0;
        while (!(s_avalid && s_addr == 32'h5080) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("t7_sub2", 64'(s_addr), 64'h5080);
        rst = 1'b0;
        #1;
        check_reset("t7_rst");
        exp_a.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        s_dready = 1'b1;
        push_a(32'h0200, 8'd3);
        lastq = '{4};
        push_data(8'd8, 4);
        fork
            send_addr(32'h0200, 8'd3);
            send_data(4, 0, 8'd8);
        join
        wait_drain("t7_drain");
        check("t7_last_err", 64'(last_err), 64'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
